// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Holds the fetch FSM state encoding, the ibus request/response shapes and
// the F/D payload, plus the sequential-PC helper.
package fetch_ctrl_pkg;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
   localparam int unsigned DEFAULT_PC_STEP  = 32'd4;
   // Hold-buffer payload: {misalign, pc[63:0], raw_instr[31:0]}
   localparam int unsigned HOLD_W           = 32'd97;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      DROP = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] raw_instr;
      logic        valid;
   } fetch_data_t;

   // Sequential PC; wraps modulo 2^64 without any flag.
   function automatic logic [63:0] pc_add(input logic [63:0] pc, input logic [63:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/fetch_ctrl_hold_buf.sv
// One-entry skid register that parks a returned instruction while decode stalls.
// Clear takes priority over load so a redirect always empties the entry.
module fetch_ctrl_hold_buf #(
   parameter int unsigned W = 32'd8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Entry register: synchronous active-low reset, clear wins over load.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer and ibus controller.
// Keeps the ibus request stable until data_ok, parks redirects that arrive
// mid-transaction (DROP) and skids one instruction while decode stalls (HOLD).
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the misalign output and
// suppresses bus requests for PCs with pc[1:0] != 0.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic        clk,
   input  logic        resetn,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output fetch_data_t dataF,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic        misalign,
`endif
   output logic        fetch_busy
);

   localparam logic [63:0] STEP_64 = 64'(PC_STEP);

   fetch_state_t r_state, w_next_state;
   logic [63:0]  r_pc, w_next_pc;
   logic [63:0]  r_redir_tgt, w_next_tgt;
   logic         r_redir_pend, w_next_pend;

   logic              w_pc_misaligned;
   logic              w_misalign;
   fetch_data_t       w_data;
   logic              w_hb_load, w_hb_clear, w_hb_valid;
   logic [HOLD_W-1:0] w_hb_din, w_hb_q;
   logic              w_hb_mis;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_pc_misaligned = (r_pc[1:0] != 2'b00);
`else
   assign w_pc_misaligned = 1'b0;
`endif

   // Whatever is being presented on dataF is what gets parked on a stall.
   assign w_hb_din = {w_misalign, w_data.pc, w_data.raw_instr};
   assign w_hb_mis = w_hb_q[HOLD_W-1];

   fetch_ctrl_hold_buf #(.W(HOLD_W)) u_hold_buf (
      .clk     (clk),
      .resetn  (resetn),
      .i_load  (w_hb_load),
      .i_clear (w_hb_clear),
      .i_data  (w_hb_din),
      .o_valid (w_hb_valid),
      .o_data  (w_hb_q)
   );

   // State, PC and pending-redirect registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= REQ;
         r_pc         <= RESET_PC;
         r_redir_tgt  <= 64'h0;
         r_redir_pend <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_pc         <= w_next_pc;
         r_redir_tgt  <= w_next_tgt;
         r_redir_pend <= w_next_pend;
      end
   end

   // Next-state, bus request and fetch output; redirect outranks stall everywhere.
   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_tgt   = r_redir_tgt;
      w_next_pend  = r_redir_pend;
      w_hb_load    = 1'b0;
      w_hb_clear   = 1'b0;
      w_misalign   = 1'b0;
      w_data       = '0;
      ireq         = '0;
      case (r_state)
         REQ: begin
            if (w_pc_misaligned) begin
               // No bus access: report the bad PC until a redirect replaces it.
               if (redirect_valid) begin
                  w_next_pc = redirect_pc;
               end else begin
                  w_data     = '{pc: r_pc, raw_instr: 32'h0, valid: 1'b1};
                  w_misalign = 1'b1;
                  if (stall) begin
                     w_hb_load    = 1'b1;
                     w_next_state = HOLD;
                  end else begin
                     w_next_state = REQ;
                  end
               end
            end else begin
               ireq.valid = 1'b1;
               ireq.addr  = r_pc;
               if (redirect_valid) begin
                  if (iresp.data_ok) begin
                     // Returned word belongs to the wrong path: drop it.
                     w_next_pc = redirect_pc;
                  end else begin
                     // Address must stay stable; finish the access first.
                     w_next_tgt   = redirect_pc;
                     w_next_pend  = 1'b1;
                     w_next_state = DROP;
                  end
               end else if (iresp.data_ok) begin
                  w_data = '{pc: r_pc, raw_instr: iresp.data, valid: 1'b1};
                  if (stall) begin
                     w_hb_load    = 1'b1;
                     w_next_state = HOLD;
                  end else begin
                     w_next_pc = pc_add(r_pc, STEP_64);
                  end
               end else begin
                  w_next_state = REQ;
               end
            end
         end
         DROP: begin
            ireq.valid = 1'b1;
            ireq.addr  = r_pc;
            if (redirect_valid) begin
               w_next_tgt = redirect_pc;
            end else begin
               w_next_tgt = r_redir_tgt;
            end
            if (iresp.data_ok) begin
               if (redirect_valid) begin
                  w_next_pc = redirect_pc;
               end else if (r_redir_pend) begin
                  w_next_pc = r_redir_tgt;
               end else begin
                  w_next_pc = r_pc;
               end
               w_next_pend  = 1'b0;
               w_next_state = REQ;
            end else begin
               w_next_state = DROP;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               w_hb_clear   = 1'b1;
               w_next_pc    = redirect_pc;
               w_next_state = REQ;
            end else begin
               w_data     = '{pc: w_hb_q[95:32], raw_instr: w_hb_q[31:0], valid: w_hb_valid};
               w_misalign = w_hb_mis;
               if (!stall) begin
                  w_hb_clear   = 1'b1;
                  // A parked misalign report does not advance; it repeats until redirected.
                  if (w_hb_mis) begin
                     w_next_pc = r_pc;
                  end else begin
                     w_next_pc = pc_add(r_pc, STEP_64);
                  end
                  w_next_state = REQ;
               end else begin
                  w_next_state = HOLD;
               end
            end
         end
         default: begin
            w_next_state = REQ;
         end
      endcase
   end

   assign dataF      = resetn ? w_data : '0;
   assign fetch_busy = ireq.valid;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign   = resetn & w_misalign;
`endif

endmodule
